fft_stage_seq: RTL and testbench

- Frame sequencer for one radix-2 FFT stage: 16 lanes per clock, 12-bit I/Q.
- Turns a per-frame start strobe into the stage control signals: shift-register enable, add/sub-path input mux select, butterfly enable and output-valid window.
- Sits beside the stage datapath and replaces ad-hoc counters and valid-delay chains inside it.
- One instance per stage; FRAME_LEN and OUT_LAT are set per stage.

---
 rtl/fft_stage_seq_if.sv | 34 +++
 rtl/fft_stage_seq.sv | 110 +++++++++++
 tb/tb_fft_stage_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_seq_if.sv
// Control bundle between a radix-2 FFT stage sequencer and its stage datapath.
// The master side issues frame strobes; the slave side returns stage controls.
interface fft_stage_seq_if;
    logic       din_valid;
    logic       sr_en;
    logic       mux_sel;
    logic       bfly_en;
    logic       dout_valid;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    modport master (
        output din_valid,
        input  sr_en,
        input  mux_sel,
        input  bfly_en,
        input  dout_valid,
        input  busy,
        input  frame_done,
        input  frame_cnt
    );

    modport slave (
        input  din_valid,
        output sr_en,
        output mux_sel,
        output bfly_en,
        output dout_valid,
        output busy,
        output frame_done,
        output frame_cnt
    );
endinterface

// File: rtl/fft_stage_seq.sv
// Frame sequencer for one radix-2 FFT stage: turns a frame start strobe
// into shift enable, add/sub mux select, butterfly enable and output valid.
module fft_stage_seq #(
    parameter int FRAME_LEN = 32,
    parameter int GRP_LEN   = 4,
    parameter int OUT_LAT   = 4,
    parameter int CNT_W     = 6
) (
    input  logic           clk,
    input  logic           rstn,
    fft_stage_seq_if.slave bus
);

    localparam int GB = $clog2(GRP_LEN);
    localparam int DW = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [DW-1:0]    DRN_LAST = DW'(OUT_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_n;
    logic [DW-1:0]    drain_cnt;
    logic [DW-1:0]    drain_n;
    logic [OUT_LAT-1:0] vld_dl;
    logic             sr_en_q;
    logic             mux_sel_q;
    logic             bfly_en_q;
    logic             busy_q;
    logic             frame_done_q;
    logic [7:0]       frame_cnt_q;
    logic             frame_end;

    assign frame_end = (state == RUN) && (cyc_cnt == CYC_LAST);

    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        drain_n = drain_cnt;
        case (state)
            IDLE: begin
                cyc_n = '0;
                if (bus.din_valid) state_n = RUN;
            end
            RUN: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_n   = '0;
                    drain_n = '0;
                    if (!bus.din_valid) state_n = DRAIN;
                end else begin
                    cyc_n = cyc_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                cyc_n = '0;
                if (bus.din_valid) begin
                    state_n = RUN;
                end else if (drain_cnt == DRN_LAST) begin
                    state_n = IDLE;
                end else begin
                    drain_n = drain_cnt + DW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
                drain_n = '0;
            end
        endcase
    end

    // Outputs are computed from next-state so they align with the state they decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            drain_cnt    <= '0;
            sr_en_q      <= 1'b0;
            mux_sel_q    <= 1'b0;
            bfly_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            vld_dl       <= '0;
        end else begin
            state        <= state_n;
            cyc_cnt      <= cyc_n;
            drain_cnt    <= drain_n;
            sr_en_q      <= (state_n == RUN);
            mux_sel_q    <= (state_n == RUN) && cyc_n[GB-1];
            bfly_en_q    <= mux_sel_q;
            busy_q       <= (state_n != IDLE);
            frame_done_q <= frame_end;
            if (frame_end) frame_cnt_q <= frame_cnt_q + 8'd1;
            vld_dl[0] <= sr_en_q;
            for (int i = 1; i < OUT_LAT; i++) vld_dl[i] <= vld_dl[i-1];
        end
    end

    assign bus.sr_en      = sr_en_q;
    assign bus.mux_sel    = mux_sel_q;
    assign bus.bfly_en    = bfly_en_q;
    assign bus.dout_valid = vld_dl[OUT_LAT-1];
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq: default instance plus a
// FRAME_LEN=16/GRP_LEN=2/OUT_LAT=1 instance.
module tb_fft_stage_seq;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    fft_stage_seq_if a();
    fft_stage_seq_if b();

    fft_stage_seq u_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (a)
    );

    fft_stage_seq #(
        .FRAME_LEN (16),
        .GRP_LEN   (2),
        .OUT_LAT   (1),
        .CNT_W     (5)
    ) u_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] exp_fc = 8'd0;

    // Expected {sr_en,mux_sel,bfly_en,dout_valid,frame_done,busy} in cycle j,
    // where frame k's sr_en window starts in cycle st[k].
    function automatic logic [5:0] expv(input int j, input int fl,
                                        input int gl, input int ol,
                                        input int st[4], input int n);
        logic sr, mx, bf, dv, fd, bz;
        sr = 0; mx = 0; bf = 0; dv = 0; fd = 0; bz = 0;
        for (int k = 0; k < n; k++) begin
            if (j >= st[k] && j < st[k] + fl) begin
                sr = 1;
                if (((j - st[k]) % gl) >= gl / 2) mx = 1;
            end
            if (j - 1 >= st[k] && j - 1 < st[k] + fl &&
                ((j - 1 - st[k]) % gl) >= gl / 2) bf = 1;
            if (j >= st[k] + ol && j < st[k] + fl + ol) dv = 1;
            if (j == st[k] + fl) fd = 1;
            if (j >= st[k] && j < st[k] + fl + ol) bz = 1;
        end
        return {sr, mx, bf, dv, fd, bz};
    endfunction

    function automatic logic [5:0] obs_a();
        return {a.sr_en, a.mux_sel, a.bfly_en, a.dout_valid,
                a.frame_done, a.busy};
    endfunction

    function automatic logic [5:0] obs_b();
        return {b.sr_en, b.mux_sel, b.bfly_en, b.dout_valid,
                b.frame_done, b.busy};
    endfunction

    task automatic test_reset();
        a.din_valid = 1'b0;
        b.din_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_chk++;
        if (obs_a() !== 6'b0 || a.frame_cnt !== 8'd0)
            $display("FAIL reset_a: got %b/%0d want 000000/0", obs_a(), a.frame_cnt);
        else n_pass++;
        n_chk++;
        if (obs_b() !== 6'b0 || b.frame_cnt !== 8'd0)
            $display("FAIL reset_b: got %b/%0d want 000000/0", obs_b(), b.frame_cnt);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        exp_fc = 8'd0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_a() !== 6'b0)
            $display("FAIL idle_after_reset: got %b want 000000", obs_a());
        else n_pass++;
    endtask

    task automatic test_single_frame(input string tag);
        int         st[4];
        logic [5:0] e;
        logic [5:0] o;
        st = '{1, 0, 0, 0};
        @(negedge clk);
        a.din_valid = 1'b1;
        @(posedge clk);
        #1 a.din_valid = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            e = expv(j, 32, 4, 4, st, 1);
            o = obs_a();
            n_chk++;
            if (o !== e)
                $display("FAIL %s cyc %0d: got %b want %b", tag, j, o, e);
            else n_pass++;
            if (j == 32) begin
                n_chk++;
                if (a.frame_cnt !== exp_fc)
                    $display("FAIL %s_fcnt_pre: got %0d want %0d", tag, a.frame_cnt, exp_fc);
                else n_pass++;
            end
        end
        exp_fc = exp_fc + 8'd1;
        n_chk++;
        if (a.frame_cnt !== exp_fc)
            $display("FAIL %s_fcnt: got %0d want %0d", tag, a.frame_cnt, exp_fc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         st[4];
        logic [5:0] e;
        logic [5:0] o;
        st = '{1, 33, 65, 97};
        @(negedge clk);
        a.din_valid = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 140; j++) begin
            @(negedge clk);
            e = expv(j, 32, 4, 4, st, 4);
            o = obs_a();
            n_chk++;
            if (o !== e)
                $display("FAIL b2b cyc %0d: got %b want %b", j, o, e);
            else n_pass++;
            a.din_valid = (j < 100);
        end
        exp_fc = exp_fc + 8'd4;
        n_chk++;
        if (a.frame_cnt !== exp_fc)
            $display("FAIL b2b_fcnt: got %0d want %0d", a.frame_cnt, exp_fc);
        else n_pass++;
    endtask

    task automatic test_drain_restart();
        int         st[4];
        logic [5:0] e;
        logic [5:0] o;
        st = '{1, 35, 0, 0};
        @(negedge clk);
        a.din_valid = 1'b1;
        @(posedge clk);
        #1 a.din_valid = 1'b0;
        for (int j = 1; j <= 80; j++) begin
            @(negedge clk);
            e = expv(j, 32, 4, 4, st, 2);
            o = obs_a();
            n_chk++;
            if (o !== e)
                $display("FAIL drain cyc %0d: got %b want %b", j, o, e);
            else n_pass++;
            a.din_valid = (j == 34);
        end
        exp_fc = exp_fc + 8'd2;
        n_chk++;
        if (a.frame_cnt !== exp_fc)
            $display("FAIL drain_fcnt: got %0d want %0d", a.frame_cnt, exp_fc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int         st[4];
        logic [5:0] e;
        logic [5:0] o;
        st = '{1, 0, 0, 0};
        @(negedge clk);
        a.din_valid = 1'b1;
        @(posedge clk);
        #1 a.din_valid = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            e = expv(j, 32, 4, 4, st, 1);
            o = obs_a();
            n_chk++;
            if (o !== e)
                $display("FAIL prerst cyc %0d: got %b want %b", j, o, e);
            else n_pass++;
        end
        rstn = 1'b0;
        #1;
        n_chk++;
        if (obs_a() !== 6'b0 || a.frame_cnt !== 8'd0)
            $display("FAIL async_rst: got %b/%0d want 000000/0", obs_a(), a.frame_cnt);
        else n_pass++;
        @(posedge clk);
        #1;
        n_chk++;
        if (obs_a() !== 6'b0)
            $display("FAIL rst_hold: got %b want 000000", obs_a());
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        exp_fc = 8'd0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a() !== 6'b0 || a.frame_cnt !== 8'd0)
                $display("FAIL post_rst_idle %0d: got %b/%0d want 000000/0",
                         j, obs_a(), a.frame_cnt);
            else n_pass++;
        end
        test_single_frame("post_rst");
    endtask

    task automatic test_wrap();
        int gaps;
        int fds;
        gaps = 0;
        fds  = 0;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        exp_fc = 8'd0;
        a.din_valid = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 8200; j++) begin
            @(negedge clk);
            if (j <= 8192 && a.sr_en !== 1'b1) gaps++;
            if (a.frame_done === 1'b1) fds++;
            if (j == 33) begin
                n_chk++;
                if (a.frame_cnt !== 8'd1)
                    $display("FAIL wrap_first: got %0d want 1", a.frame_cnt);
                else n_pass++;
            end
            if (j == 8192) begin
                n_chk++;
                if (a.frame_cnt !== 8'd255)
                    $display("FAIL wrap_255: got %0d want 255", a.frame_cnt);
                else n_pass++;
            end
            if (j == 8193) begin
                n_chk++;
                if (a.frame_cnt !== 8'd0 || a.frame_done !== 1'b1)
                    $display("FAIL wrap_zero: got %0d/%b want 0/1",
                             a.frame_cnt, a.frame_done);
                else n_pass++;
            end
            a.din_valid = (j <= 8160);
        end
        n_chk++;
        if (gaps != 0)
            $display("FAIL wrap_sr_gaps: got %0d want 0", gaps);
        else n_pass++;
        n_chk++;
        if (fds != 256)
            $display("FAIL wrap_done_cnt: got %0d want 256", fds);
        else n_pass++;
        n_chk++;
        if (a.busy !== 1'b0)
            $display("FAIL wrap_idle: got %b want 0", a.busy);
        else n_pass++;
    endtask

    task automatic test_param_sweep();
        int         st[4];
        logic [5:0] e;
        logic [5:0] o;
        st = '{1, 0, 0, 0};
        @(negedge clk);
        b.din_valid = 1'b1;
        @(posedge clk);
        #1 b.din_valid = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            e = expv(j, 16, 2, 1, st, 1);
            o = obs_b();
            n_chk++;
            if (o !== e)
                $display("FAIL sweep cyc %0d: got %b want %b", j, o, e);
            else n_pass++;
        end
        n_chk++;
        if (b.frame_cnt !== 8'd1)
            $display("FAIL sweep_fcnt: got %0d want 1", b.frame_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame("single");
        test_back_to_back();
        test_drain_restart();
        test_reset_mid_frame();
        test_wrap();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
